if_fetch: RTL and testbench

- Instruction-fetch stage; sits directly upstream of the IF/ID pipeline register.
- Owns the program counter and drives a request/acknowledge instruction bus.
- Presents if_pc/if_inst to IF/ID and raises stallreq_from_if while an instruction is outstanding.
- Applies exception redirects (flush/new_pc) and branch redirects; discards any in-flight response that belongs to a squashed path.

---
 rtl/if_fetch_pkg.sv | 19 +
 rtl/if_fetch.sv | 130 +++++++++++++
 tb/tb_if_fetch.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_pkg.sv
// Shared encodings and widths for the instruction-fetch stage.
package if_fetch_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  localparam logic [INST_W-1:0]      ZERO_WORD = '0;
  localparam logic [INST_ADDR_W-1:0] PC_STEP   = 32'd4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_VALID = 2'd2;
  localparam logic [1:0] S_DROP  = 2'd3;

  function automatic logic [INST_ADDR_W-1:0] next_seq_pc(input logic [INST_ADDR_W-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, drives the req/ack ibus, feeds IF/ID; IF_FETCH_TIMEOUT_EN adds a sticky watchdog.
// Latency: 2 cycles per instruction minimum (request with same-cycle ack, then valid cycle).
// Backpressure: stall[0] holds the valid instruction; stallreq_from_if is high while a request is outstanding.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC       = 32'h0000_0000,
  parameter int                     TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             stall,
  input  logic                   flush,
  input  logic [INST_ADDR_W-1:0] new_pc,
  input  logic                   branch_flag_i,
  input  logic [INST_ADDR_W-1:0] branch_target_address_i,
  output logic                   ibus_req_o,
  output logic [INST_ADDR_W-1:0] ibus_addr_o,
  input  logic                   ibus_ack_i,
  input  logic [INST_W-1:0]      ibus_rdata_i,
  output logic [INST_ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0]      if_inst,
  output logic                   stallreq_from_if,
  output logic                   fetch_timeout_o
);

  logic [1:0]             state;
  logic [INST_ADDR_W-1:0] fetch_pc;
  logic [INST_ADDR_W-1:0] req_addr;
  logic [INST_W-1:0]      inst_q;

  logic                   redirect;
  logic [INST_ADDR_W-1:0] target;
  logic                   waiting;

  // Exception flush is unconditional; a branch only lands when the PC stage is free.
  assign redirect = flush | (branch_flag_i & ~stall[0]);
  assign target   = flush ? new_pc : branch_target_address_i;
  assign waiting  = (state == S_REQ) || (state == S_DROP);

  always_comb begin
    ibus_req_o       = waiting;
    ibus_addr_o      = waiting ? req_addr : ZERO_WORD;
    stallreq_from_if = waiting;
    if_pc            = (state == S_VALID) ? fetch_pc : ZERO_WORD;
    if_inst          = (state == S_VALID) ? inst_q : ZERO_WORD;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      inst_q   <= ZERO_WORD;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_REQ;
          if (redirect) begin
            fetch_pc <= target;
            req_addr <= target;
          end else begin
            req_addr <= fetch_pc;
          end
        end
        S_REQ: begin
          if (redirect) begin
            fetch_pc <= target;
            if (ibus_ack_i) begin
              req_addr <= target;
            end else begin
              // Bus request must stay up until acked; its data is thrown away.
              state <= S_DROP;
            end
          end else if (ibus_ack_i) begin
            inst_q <= ibus_rdata_i;
            state  <= S_VALID;
          end
        end
        S_VALID: begin
          if (redirect) begin
            fetch_pc <= target;
            req_addr <= target;
            state    <= S_REQ;
          end else if (!stall[0]) begin
            fetch_pc <= next_seq_pc(fetch_pc);
            req_addr <= next_seq_pc(fetch_pc);
            state    <= S_REQ;
          end
        end
        default: begin
          if (redirect) fetch_pc <= target;
          if (ibus_ack_i) begin
            req_addr <= redirect ? target : fetch_pc;
            state    <= S_REQ;
          end
        end
      endcase
    end
  end

`ifdef IF_FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_cnt;
  logic          timeout_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else if (waiting && !ibus_ack_i) begin
      if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) timeout_q <= 1'b1;
      else                                     wait_cnt  <= wait_cnt + CW'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  assign fetch_timeout_o = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout  = (TIMEOUT_CYCLES != 0);
  assign fetch_timeout_o = 1'b0;
`endif

  logic unused_stall;
  assign unused_stall = ^stall[5:1];

endmodule

// File: tb/tb_if_fetch.sv
// Randomized + directed bench for if_fetch against a transaction-level fetch model.
module tb_if_fetch;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int          TMO = 8;
`ifdef IF_FETCH_TIMEOUT_EN
  localparam logic EXP_TO = 1'b1;
`else
  localparam logic EXP_TO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_ack_i;
  logic [31:0] ibus_rdata_i;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_from_if;
  logic        fetch_timeout_o;

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(RPC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .branch_flag_i(branch_flag_i), .branch_target_address_i(branch_target_address_i),
    .ibus_req_o(ibus_req_o), .ibus_addr_o(ibus_addr_o), .ibus_ack_i(ibus_ack_i),
    .ibus_rdata_i(ibus_rdata_i), .if_pc(if_pc), .if_inst(if_inst),
    .stallreq_from_if(stallreq_from_if), .fetch_timeout_o(fetch_timeout_o)
  );

  int checks = 0;
  int passed = 0;

  // Model: a pending bus request (possibly for a squashed path) or a held instruction.
  logic [31:0] m_pc, m_addr, m_inst;
  bit          m_boot, m_busy, m_stale, m_hold, m_to;
  int          m_wait;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc = RPC; m_addr = RPC; m_inst = '0;
    m_boot = 1'b1; m_busy = 1'b0; m_stale = 1'b0; m_hold = 1'b0;
    m_to = 1'b0; m_wait = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".req"},   32'(ibus_req_o),       32'(m_busy));
    chk({tag, ".addr"},  ibus_addr_o,           m_busy ? m_addr : 32'h0);
    chk({tag, ".pc"},    if_pc,                 m_hold ? m_pc : 32'h0);
    chk({tag, ".inst"},  if_inst,               m_hold ? m_inst : 32'h0);
    chk({tag, ".stall"}, 32'(stallreq_from_if), 32'(m_busy));
    chk({tag, ".to"},    32'(fetch_timeout_o),  32'(m_to & EXP_TO));
  endtask

  task automatic model_step();
    bit          redir;
    logic [31:0] t;
    redir = flush | (branch_flag_i & ~stall[0]);
    t     = flush ? new_pc : branch_target_address_i;
    if (m_busy && !ibus_ack_i) begin
      m_wait++;
      if (m_wait >= TMO) m_to = 1'b1;
    end else begin
      m_wait = 0;
    end
    if (m_boot) begin
      m_boot = 1'b0; m_busy = 1'b1;
      if (redir) m_pc = t;
      m_addr = m_pc;
    end else if (m_hold) begin
      if (redir || !stall[0]) begin
        m_pc   = redir ? t : m_pc + 32'd4;
        m_addr = m_pc;
        m_hold = 1'b0; m_busy = 1'b1;
      end
    end else if (m_busy) begin
      if (ibus_ack_i) begin
        if (m_stale) begin
          m_stale = 1'b0;
          if (redir) m_pc = t;
          m_addr = m_pc;
        end else if (redir) begin
          m_pc = t; m_addr = t;
        end else begin
          m_busy = 1'b0; m_hold = 1'b1; m_inst = ibus_rdata_i;
        end
      end else if (redir) begin
        m_pc = t; m_stale = 1'b1;
      end
    end
  endtask

  task automatic cycle(input bit f, input logic [31:0] npc, input bit br, input logic [31:0] tgt,
                       input logic [5:0] st, input bit ack, input logic [31:0] rd);
    flush = f; new_pc = npc; branch_flag_i = br; branch_target_address_i = tgt;
    stall = st; ibus_ack_i = ack; ibus_rdata_i = rd;
    check_outputs("cyc");
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; stall = '0; flush = 1'b0; new_pc = '0; branch_flag_i = 1'b0;
    branch_target_address_i = '0; ibus_ack_i = 1'b0; ibus_rdata_i = '0;
    model_reset();
    #12;
    chk("rst.req", 32'(ibus_req_o), 32'h0);
    chk("rst.addr", ibus_addr_o, 32'h0);
    chk("rst.pc", if_pc, 32'h0);
    chk("rst.inst", if_inst, 32'h0);
    chk("rst.stall", 32'(stallreq_from_if), 32'h0);
    chk("rst.to", 32'(fetch_timeout_o), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Back-to-back fetches with same-cycle ack.
    cycle(0, 0, 0, 0, 6'h00, 0, 0);
    chk("seq.addr0", ibus_addr_o, 32'h0);
    chk("seq.req0", 32'(stallreq_from_if), 32'h1);
    cycle(0, 0, 0, 0, 6'h00, 1, 32'hA000_0000);
    chk("seq.inst0", if_inst, 32'hA000_0000);
    chk("seq.stall0", 32'(stallreq_from_if), 32'h0);
    cycle(0, 0, 0, 0, 6'h00, 0, 0);
    chk("seq.addr4", ibus_addr_o, 32'h4);
    cycle(0, 0, 0, 0, 6'h00, 1, 32'hA000_0004);
    cycle(0, 0, 0, 0, 6'h00, 0, 0);
    chk("seq.addr8", ibus_addr_o, 32'h8);

    // Delayed ack: request held for four cycles.
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 6'h00, 0, 0);
      chk("hold.addr8", ibus_addr_o, 32'h8);
      chk("hold.inst", if_inst, 32'h0);
    end
    cycle(0, 0, 0, 0, 6'h00, 1, 32'hA000_0008);
    chk("hold.pc8", if_pc, 32'h8);

    // Branch blocked by stall[0], then accepted.
    cycle(0, 0, 1, 32'h400, 6'h01, 0, 0);
    chk("br.stalled.pc", if_pc, 32'h8);
    chk("br.stalled.req", 32'(ibus_req_o), 32'h0);
    cycle(0, 0, 1, 32'h400, 6'h00, 0, 0);
    chk("br.addr", ibus_addr_o, 32'h400);

    // Flush while unacked: old address kept, its data squashed.
    cycle(1, 32'h180, 0, 0, 6'h00, 0, 0);
    chk("drop.addr", ibus_addr_o, 32'h400);
    chk("drop.inst", if_inst, 32'h0);
    cycle(0, 0, 0, 0, 6'h00, 1, 32'hDEAD_BEEF);
    chk("drop.next", ibus_addr_o, 32'h180);
    cycle(0, 0, 0, 0, 6'h00, 1, 32'hA000_0180);
    chk("drop.inst2", if_inst, 32'hA000_0180);

    // Flush and branch together: flush wins.
    cycle(1, 32'h200, 1, 32'h400, 6'h00, 0, 0);
    chk("prio.addr", ibus_addr_o, 32'h200);

    // Withheld ack trips the watchdog (when built in), which stays sticky.
    for (int i = 0; i < 9; i++) cycle(0, 0, 0, 0, 6'h00, 0, 0);
    chk("to.set", 32'(fetch_timeout_o), 32'(EXP_TO));
    cycle(0, 0, 0, 0, 6'h00, 1, 32'hA000_0200);
    chk("to.sticky", 32'(fetch_timeout_o), 32'(EXP_TO));

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : $urandom;
      cycle(($urandom_range(15) == 0), $urandom, ($urandom_range(5) == 0), tgt,
            {5'($urandom), ($urandom_range(3) == 0)}, ($urandom_range(2) == 0), $urandom);
    end

    // Async reset in the middle of an outstanding request.
    for (int i = 0; i < 20 && !m_busy; i++) cycle(0, 0, 0, 0, 6'h00, 0, 0);
    chk("mid.busy", 32'(ibus_req_o), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("mid.req", 32'(ibus_req_o), 32'h0);
    chk("mid.addr", ibus_addr_o, 32'h0);
    chk("mid.inst", if_inst, 32'h0);
    chk("mid.stall", 32'(stallreq_from_if), 32'h0);
    chk("mid.to", 32'(fetch_timeout_o), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cycle(0, 0, 0, 0, 6'h00, 0, 0);
    chk("post.addr", ibus_addr_o, RPC);
    chk("post.req", 32'(ibus_req_o), 32'h1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 6'h00, 1, $urandom);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
